// File: rtl/mips_store_buffer.sv
// Posted-write store buffer: core stores queue in a FIFO and drain over a req/ack port; loads forward youngest-first.
// Optional build macro STORE_BUF_COALESCE_EN merges a store into the youngest non-head entry with the same word address.
module mips_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clock__i,
    input  logic                       reset_n__i,
    input  logic [ADDR_W-1:0]          memAddr__i,
    input  logic [DATA_W-1:0]          memDataWrite__i,
    input  logic                       memRead__i,
    input  logic                       memWrite__i,
    output logic [DATA_W-1:0]          memDataRead__o,
    output logic [ADDR_W-1:0]          extRdAddr__o,
    input  logic [DATA_W-1:0]          extRdData__i,
    output logic                       extWrReq__o,
    output logic [ADDR_W-1:0]          extWrAddr__o,
    output logic [DATA_W-1:0]          extWrData__o,
    input  logic                       extWrAck__i,
    output logic                       full__o,
    output logic                       empty__o,
    output logic                       overflow__o,
    output logic [$clog2(DEPTH):0]     count__o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] entry_addr  [DEPTH];
    logic [DATA_W-1:0] entry_data  [DEPTH];
    logic              entry_valid [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  youngest;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;

    logic              pop;
    logic              push;
    logic              drop;
    logic              coalesce;
    logic              has_room;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  scan_idx;

    function automatic logic word_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

    assign full__o     = (count == DEPTH_CNT);
    assign empty__o    = (count == '0);
    assign overflow__o = overflow_q;
    assign count__o    = count;

    // Write port handshake: extWrReq__o is the valid, extWrAck__i the ready; a
    // transfer (pop) happens on an edge with both high, and addr/data stay
    // stable from the first cycle of valid until that edge.
    assign extWrReq__o  = !empty__o;
    assign extWrAddr__o = empty__o ? '0 : {entry_addr[head][ADDR_W-1:2], 2'b00};
    assign extWrData__o = empty__o ? '0 : entry_data[head];
    assign pop          = extWrReq__o && extWrAck__i;

    assign youngest = tail - PTR_W'(1);

`ifdef STORE_BUF_COALESCE_EN
    // Requiring two entries keeps the youngest distinct from the head under handshake.
    assign coalesce = memWrite__i && (count >= CNT_W'(2)) && entry_valid[youngest]
                      && word_eq(entry_addr[youngest], memAddr__i);
`else
    assign coalesce = 1'b0;
`endif

    assign has_room = !full__o || pop;
    assign push     = memWrite__i && !coalesce && has_room;
    assign drop     = memWrite__i && !coalesce && !has_room;

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i]  <= '0;
                entry_data[i]  <= '0;
                entry_valid[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_W'(1);
            end
            // On a full push+pop tail equals head; this later write re-validates the slot.
            if (push) begin
                entry_addr[tail]  <= memAddr__i;
                entry_data[tail]  <= memDataWrite__i;
                entry_valid[tail] <= 1'b1;
                tail              <= tail + PTR_W'(1);
            end
            if (coalesce) begin
                entry_addr[youngest] <= memAddr__i;
                entry_data[youngest] <= memDataWrite__i;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entry_valid[scan_idx]
                && word_eq(entry_addr[scan_idx], memAddr__i)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[scan_idx];
            end
        end
    end

    assign extRdAddr__o   = {memAddr__i[ADDR_W-1:2], 2'b00};
    assign memDataRead__o = (memRead__i && fwd_hit) ? fwd_data : extRdData__i;

    a_count_bound: assert property (@(posedge clock__i) disable iff (!reset_n__i)
        count <= DEPTH_CNT);

    a_wr_stable: assert property (@(posedge clock__i) disable iff (!reset_n__i)
        (extWrReq__o && !extWrAck__i) |=> ($stable(extWrAddr__o) && $stable(extWrData__o)));

endmodule

// File: tb/tb_mips_store_buffer.sv
// Directed bench for mips_store_buffer: handshake, forwarding, overflow, full push+pop, streaming, coalescing.
// Expected values are hand-derived; drain order is checked against an expected queue.
module tb_mips_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int W      = ADDR_W + DATA_W;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] ext_rd_addr;
    logic [DATA_W-1:0] ext_rd_data;
    logic              ext_wr_req;
    logic [ADDR_W-1:0] ext_wr_addr;
    logic [DATA_W-1:0] ext_wr_data;
    logic              ext_wr_ack;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [2:0]        count;

    int total;
    int bad;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    mips_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock__i        (clk),
        .reset_n__i      (reset_n),
        .memAddr__i      (mem_addr),
        .memDataWrite__i (mem_wdata),
        .memRead__i      (mem_read),
        .memWrite__i     (mem_write),
        .memDataRead__o  (mem_rdata),
        .extRdAddr__o    (ext_rd_addr),
        .extRdData__i    (ext_rd_data),
        .extWrReq__o     (ext_wr_req),
        .extWrAddr__o    (ext_wr_addr),
        .extWrData__o    (ext_wr_data),
        .extWrAck__i     (ext_wr_ack),
        .full__o         (full),
        .empty__o        (empty),
        .overflow__o     (overflow),
        .count__o        (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ext_rd_data = '0;
        ext_wr_ack  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // driver: one store strobe for one cycle
    task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    // drain everything with ack held high, checking each transfer against exp_q
    task automatic drain_check(input string name, input int budget);
        ext_wr_ack = 1'b1;
        for (int k = 0; k < budget && !empty; k++) begin
            #1;
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            total++;
            if ({ext_wr_addr, ext_wr_data} !== exp_e) begin
                bad++;
                $display("FAIL %s drain[%0d]: got addr=%h data=%h want addr=%h data=%h",
                         name, k, ext_wr_addr, ext_wr_data, exp_e[W-1:DATA_W], exp_e[DATA_W-1:0]);
            end
            tick();
        end
        ext_wr_ack = 1'b0;
        #1;
        total++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain_end: empty=%b left=%0d want empty=1 left=0", name, empty, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) tick();
        total++;
        if ({empty, full, ext_wr_req, overflow} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: empty/full/req/ovf=%b want 1000", {empty, full, ext_wr_req, overflow});
        end
        total++;
        if (count !== 3'd0 || ext_wr_addr !== '0 || ext_wr_data !== '0) begin
            bad++;
            $display("FAIL reset_regs: count=%0d waddr=%h wdata=%h want 0 0 0", count, ext_wr_addr, ext_wr_data);
        end
    endtask

    task automatic test_handshake();
        do_reset();
        drive_store(32'h100, 32'hAAAA0001);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (ext_wr_req !== 1'b1 || ext_wr_addr !== 32'h100 || ext_wr_data !== 32'hAAAA0001) begin
                bad++;
                $display("FAIL handshake_hold[%0d]: req=%b addr=%h data=%h want 1 100 aaaa0001",
                         k, ext_wr_req, ext_wr_addr, ext_wr_data);
            end
            if (k < 3) tick();
        end
        ext_wr_ack = 1'b1;
        tick();
        ext_wr_ack = 1'b0;
        #1;
        total++;
        if (empty !== 1'b1 || ext_wr_req !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL handshake_pop: empty=%b req=%b count=%0d want 1 0 0", empty, ext_wr_req, count);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive_store(32'h200, 32'h1);
        drive_store(32'h200, 32'h2);
        ext_rd_data = 32'hDEAD;
        mem_read    = 1'b1;
        mem_addr    = 32'h202;
        #1;
        total++;
        if (mem_rdata !== 32'h2 || ext_rd_addr !== 32'h200) begin
            bad++;
            $display("FAIL fwd_hit: rdata=%h rdaddr=%h want 2 200", mem_rdata, ext_rd_addr);
        end
        mem_addr = 32'h204;
        #1;
        total++;
        if (mem_rdata !== 32'hDEAD || ext_rd_addr !== 32'h204) begin
            bad++;
            $display("FAIL fwd_miss: rdata=%h rdaddr=%h want dead 204", mem_rdata, ext_rd_addr);
        end
        mem_read = 1'b0;
        mem_addr = 32'h200;
        #1;
        total++;
        if (mem_rdata !== 32'hDEAD) begin
            bad++;
            $display("FAIL fwd_no_read: rdata=%h want dead", mem_rdata);
        end
        // load and store to the same word in one cycle: no bypass of the incoming store
        mem_read  = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 32'h300;
        mem_wdata = 32'h77;
        #1;
        total++;
        if (mem_rdata !== 32'hDEAD) begin
            bad++;
            $display("FAIL fwd_same_cycle: rdata=%h want dead", mem_rdata);
        end
        tick();
        mem_write = 1'b0;
        #1;
        total++;
        if (mem_rdata !== 32'h77 || count !== 3'd3) begin
            bad++;
            $display("FAIL fwd_next_cycle: rdata=%h count=%0d want 77 3", mem_rdata, count);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_overflow();
        logic [2:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_store(ADDR_W'(i * 4), DATA_W'(32'hC0 + i));
            if (i < 4) exp_q.push_back({ADDR_W'(i * 4), DATA_W'(32'hC0 + i)});
            exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
            #1;
            total++;
            if (count !== exp_cnt || full !== (i >= 3) || overflow !== (i == 4)) begin
                bad++;
                $display("FAIL overflow_fill[%0d]: count=%0d full=%b ovf=%b want %0d %b %b",
                         i, count, full, overflow, exp_cnt, (i >= 3), (i == 4));
            end
        end
        drain_check("overflow", 8);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_store(ADDR_W'(i * 4), DATA_W'(32'h10 + i));
            if (i > 0) exp_q.push_back({ADDR_W'(i * 4), DATA_W'(32'h10 + i)});
        end
        exp_q.push_back({32'h40, 32'h40});
        ext_wr_ack = 1'b1;
        drive_store(32'h40, 32'h40);
        ext_wr_ack = 1'b0;
        #1;
        total++;
        if (count !== 3'd4 || overflow !== 1'b0 || ext_wr_addr !== 32'h4) begin
            bad++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%h want 4 0 4", count, overflow, ext_wr_addr);
        end
        drain_check("full_push_pop", 8);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs[4];
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18; addrs[3] = 32'h1B;
        do_reset();
        ext_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({addrs[i] & 32'hFFFF_FFFC, DATA_W'(32'h5000 + i)});
            mem_addr  = addrs[i];
            mem_wdata = DATA_W'(32'h5000 + i);
            mem_write = 1'b1;
            #1;
            if (ext_wr_req) begin
                exp_e = exp_q.pop_front();
                total++;
                if ({ext_wr_addr, ext_wr_data} !== exp_e) begin
                    bad++;
                    $display("FAIL b2b_stream[%0d]: got %h/%h want %h/%h", i, ext_wr_addr, ext_wr_data,
                             exp_e[W-1:DATA_W], exp_e[DATA_W-1:0]);
                end
            end
            tick();
        end
        mem_write = 1'b0;
        #1;
        total++;
        if (count !== 3'd1) begin
            bad++;
            $display("FAIL b2b_count: count=%0d want 1", count);
        end
        drain_check("b2b", 10);
    endtask

    task automatic test_coalesce();
        logic [2:0] exp_cnt;
        do_reset();
        drive_store(32'h0, 32'h1);
        drive_store(32'h8, 32'h2);
        drive_store(32'h8, 32'h3);
        exp_q.push_back({32'h0, 32'h1});
`ifdef STORE_BUF_COALESCE_EN
        exp_cnt = 3'd2;
`else
        exp_cnt = 3'd3;
        exp_q.push_back({32'h8, 32'h2});
`endif
        exp_q.push_back({32'h8, 32'h3});
        #1;
        total++;
        if (count !== exp_cnt || overflow !== 1'b0) begin
            bad++;
            $display("FAIL coalesce_count: count=%0d ovf=%b want %0d 0", count, overflow, exp_cnt);
        end
        drain_check("coalesce", 8);
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_store(32'h500, 32'h55);
        #1;
        total++;
        if (ext_wr_req !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: req=%b want 1", ext_wr_req);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (ext_wr_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL areset_mid: req=%b count=%0d empty=%b want 0 0 1", ext_wr_req, count, empty);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_handshake();
        test_forwarding();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_coalesce();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_store_buffer.md
Name: mips_store_buffer

Overview:
- Posted-write store buffer between the 5-stage core's MEM-stage data port and a slow external data memory.
- Core stores enter a FIFO and complete in zero core cycles. The FIFO drains to memory over a req/ack write handshake.
- Loads read memory through an asynchronous read port. Loads that hit a pending store are forwarded from the buffer, youngest entry first.
- Full/overflow status is exported so the hazard unit can stall the pipeline.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock__i  in  1  core clock
- reset_n__i  in  1  reset, active-low
- memAddr__i  in  ADDR_W  core data address (ALU result, MEM stage)
- memDataWrite__i  in  DATA_W  core store data
- memRead__i  in  1  core load strobe
- memWrite__i  in  1  core store strobe
- memDataRead__o  out  DATA_W  load data to core (combinational)
- extRdAddr__o  out  ADDR_W  external async read address
- extRdData__i  in  DATA_W  external async read data
- extWrReq__o  out  1  external write request
- extWrAddr__o  out  ADDR_W  external write address
- extWrData__o  out  DATA_W  external write data
- extWrAck__i  in  1  external write accept
- full__o  out  1  count == DEPTH
- empty__o  out  1  count == 0
- overflow__o  out  1  sticky: a store was dropped
- count__o  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: one clock, clock__i. Reset reset_n__i is asynchronous and active-low.
- Reset values: head/tail pointers 0, count 0, all entries invalid, empty__o=1, full__o=0, overflow__o=0, extWrReq__o=0. extWrAddr__o/extWrData__o are 0 while empty.
- Address match: compares addr[ADDR_W-1:2] only. Stored addresses keep all bits. extWrAddr__o and extRdAddr__o drive addr[1:0]=2'b00.
- Enqueue:
  - On the rising edge where memWrite__i=1 and the store is accepted, write {addr,data} at tail, tail+1 mod DEPTH, count+1.
  - A store is accepted when count<DEPTH, OR when count==DEPTH and a pop occurs in the same cycle.
- Dequeue:
  - extWrReq__o = !empty__o.
  - extWrAddr__o/extWrData__o = head entry, held stable while extWrReq__o=1 and extWrAck__i=0.
  - Pop on the edge where extWrReq__o & extWrAck__i: head+1 mod DEPTH, count-1.
- Simultaneous push and pop: count unchanged, both pointers advance. When empty, a push and an ack in the same cycle cannot pop; the entry first appears at head the next cycle. No bypass.
- Overflow: memWrite__i=1 with count==DEPTH and no pop: store dropped, state unchanged, overflow__o set. overflow__o clears only on reset.
- Load path (combinational, all in the same cycle):
  - extRdAddr__o = memAddr__i with [1:0]=0.
  - If memRead__i=1 and any valid entry matches: memDataRead__o = data of the youngest matching entry (closest to tail).
  - Otherwise memDataRead__o = extRdData__i.
- memRead__i and memWrite__i both 1: the store is handled as above. The load ignores the incoming store and forwards only already-buffered entries.
- Load latency 0 cycles. Store visible to forwarding 1 cycle after its strobe edge.
- Ordering: stores reach memory in program order. A dropped store never reaches memory.
- Reset mid-handshake: buffer contents discarded, extWrReq__o deasserts asynchronously. The external side must tolerate an abandoned request.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - A store whose word address matches the youngest valid entry overwrites that entry's data and address in place. No enqueue, count unchanged.
  - Coalescing is allowed only if that entry is not the head. The head is never modified, so handshake stability holds.
  - A coalesced store is accepted even when full (no overflow).
- Undefined: every accepted store enqueues a new entry.

Test Plan:
- Reset, then idle 5 cycles -> empty__o=1, count__o=0, extWrReq__o=0, overflow__o=0.
- Store 0x100<-0xAAAA0001 with extWrAck__i=0 -> next cycle extWrReq__o=1, extWrAddr__o=0x100, extWrData__o=0xAAAA0001, held stable 3 cycles. Ack for 1 cycle -> empty__o=1 on the next cycle.
- Stores 0x200<-1, 0x200<-2 (ack held 0), then load 0x202 with extRdData__i=0xDEAD -> memDataRead__o=2. Load 0x204 -> 0xDEAD.
- DEPTH=4, ack 0, 5 stores to 0x0,0x4,0x8,0xC,0x10 -> full__o=1 after the 4th, 5th dropped, overflow__o=1. Ack 4 cycles -> write addresses 0x0,0x4,0x8,0xC in order.
- Full buffer, store 0x40 in the same cycle as ack -> accepted, count__o stays 4, overflow__o=0, 0x40 drains last.
- With STORE_BUF_COALESCE_EN, ack 0: stores 0x0<-1, 0x8<-2, 0x8<-3 -> count__o=2, drains 0x0=1 then 0x8=3. Without the macro -> count__o=3, drains 0x8=2 then 0x8=3.
